// File: rtl/muldiv_seq.sv
// Multicycle signed MULT (radix-2 Booth) / DIV (restoring) sequencer, one iteration per clock.
// Optional define MULDIV_DIVZERO_EXC_EN: DIV by zero exits early and pulses div_zero with done.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
`ifdef MULDIV_DIVZERO_EXC_EN
  output logic             div_zero,
`endif
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // Booth register carries one guard bit above the product so the upper-half add cannot overflow.
  localparam int AW = 2 * WIDTH + 2;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, LOAD, MRUN, DRUN, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic [WIDTH:0]   upper, a_ext, sum;
  logic [WIDTH:0]   rem_sh, diff;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic             b_zero;

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_q   <= IDLE;
      op_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    upper  = acc_q[AW-1:WIDTH+1];
    a_ext  = {a_q[WIDTH-1], a_q};
    sum    = upper;
    case (acc_q[1:0])
      2'b01:   sum = upper + a_ext;
      2'b10:   sum = upper - a_ext;
      default: sum = upper;
    endcase
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    a_abs  = a_q[WIDTH-1] ? -a_q : a_q;
    b_abs  = b_q[WIDTH-1] ? -b_q : b_q;
    b_zero = (b_q == '0);
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d = '0;
        if (!op_q) begin
          acc_d   = {{(WIDTH + 1){1'b0}}, b_q, 1'b0};
          state_d = MRUN;
        end else begin
          neg_quo_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
          neg_rem_d = a_q[WIDTH-1];
          quo_d     = a_abs;
          dvs_d     = b_abs;
          rem_d     = '0;
          state_d   = DRUN;
`ifdef MULDIV_DIVZERO_EXC_EN
          if (b_zero) state_d = DONE;
`endif
        end
      end
      MRUN: begin
        acc_d = {sum[WIDTH], sum, acc_q[WIDTH:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = FIX;
      end
      DRUN: begin
        // rem_sh < 2*|b|, so a successful subtract always leaves a value that fits WIDTH bits.
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        if (!op_q) begin
          hi_d = acc_q[2*WIDTH:WIDTH+1];
          lo_d = acc_q[WIDTH:1];
        end else begin
          lo_d = neg_quo_q ? -quo_q : quo_q;
          hi_d = neg_rem_q ? -rem_q : rem_q;
`ifndef MULDIV_DIVZERO_EXC_EN
          if (b_zero) begin
            lo_d = '1;
            hi_d = a_q;
          end
`endif
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;
`ifdef MULDIV_DIVZERO_EXC_EN
  assign div_zero = done & op_q & b_zero;
`endif

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: MULT/DIV vectors, latency, start-ignore,
// back-to-back operation and asynchronous reset.
module tb_muldiv_seq;

  logic        clk;
  logic        reset_in;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef MULDIV_DIVZERO_EXC_EN
  logic        div_zero;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset_in (reset_in),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
`ifdef MULDIV_DIVZERO_EXC_EN
    .div_zero (div_zero),
`endif
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op; latency counts edges after the start edge until done is first seen.
  task automatic run_op(input string tag, input logic opv, input logic [31:0] av,
                        input logic [31:0] bv, input int inj, input int exp_lat,
                        input logic [31:0] eh, input logic [31:0] el, input logic edz);
    int lat;
    int ndone;
    logic [31:0] hs;
    logic [31:0] ls;
    logic dzs;
    lat = -1; ndone = 0; hs = '0; ls = '0; dzs = 1'b0;
    @(negedge clk);
    op = opv; a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; op = ~opv;
    for (int n = 1; n <= 45; n++) begin
      @(posedge clk);
      #1;
      if (n == inj) begin
        start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd7;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = n; hs = hi; ls = lo;
`ifdef MULDIV_DIVZERO_EXC_EN
          dzs = div_zero;
`endif
        end
      end
    end
    check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check_val({tag, "_ndone"}, 64'(ndone), 64'd1);
    check_val({tag, "_hi"}, {32'd0, hs}, {32'd0, eh});
    check_val({tag, "_lo"}, {32'd0, ls}, {32'd0, el});
`ifdef MULDIV_DIVZERO_EXC_EN
    check_val({tag, "_dz"}, {63'd0, dzs}, {63'd0, edz});
`else
    check_val({tag, "_dz"}, {63'd0, dzs}, {63'd0, edz & 1'b0});
`endif
    $display("op %s: op=%0d a=%08h b=%08h -> hi=%08h lo=%08h lat=%0d", tag, opv, av, bv, hs, ls, lat);
  endtask

  initial begin
    int d_idx[3];
    int nd;
    reset_in = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    #1 reset_in = 1'b0;
    #2;
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_done", {63'd0, done}, 64'd0);
    check_val("rst_hi", {32'd0, hi}, 64'd0);
    check_val("rst_lo", {32'd0, lo}, 64'd0);
    repeat (3) @(negedge clk);
    reset_in = 1'b1;

    run_op("mul_7xm3", 1'b0, 32'd7, 32'hFFFF_FFFD, 0, 34, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("mul_min2", 1'b0, 32'h8000_0000, 32'h8000_0000, 0, 34, 32'h4000_0000, 32'h0, 1'b0);
    run_op("mul_m5xm6", 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 0, 34, 32'h0, 32'd30, 1'b0);
    run_op("div_m7d2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_mind1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 34, 32'h0, 32'h8000_0000, 1'b0);
    run_op("div_100d7", 1'b1, 32'd100, 32'd7, 0, 34, 32'd2, 32'd14, 1'b0);
    run_op("div_7dm2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0, 34, 32'd1, 32'hFFFF_FFFD, 1'b0);
`ifdef MULDIV_DIVZERO_EXC_EN
    run_op("div_zero", 1'b1, 32'h0000_1234, 32'd0, 0, 1, 32'd1, 32'hFFFF_FFFD, 1'b1);
`else
    run_op("div_zero", 1'b1, 32'h0000_1234, 32'd0, 0, 34, 32'h0000_1234, 32'hFFFF_FFFF, 1'b0);
`endif
    run_op("mul_inj", 1'b0, 32'd7, 32'hFFFF_FFFD, 5, 34, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);

    // start held high: one MULT 5x5 accepted every 36 cycles
    nd = 0;
    d_idx[0] = -1; d_idx[1] = -1; d_idx[2] = -1;
    @(negedge clk);
    op = 1'b0; a = 32'd5; b = 32'd5; start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 140; n++) begin
      @(posedge clk);
      #1;
      if (n == 100) start = 1'b0;
      if (done) begin
        if (nd < 3) d_idx[nd] = n;
        nd++;
        check_val("b2b_hi", {32'd0, hi}, 64'd0);
        check_val("b2b_lo", {32'd0, lo}, 64'd25);
        $display("b2b done at edge +%0d hi=%08h lo=%08h", n, hi, lo);
      end
    end
    check_val("b2b_ndone", 64'(nd), 64'd3);
    check_val("b2b_d0", 64'(d_idx[0]), 64'd34);
    check_val("b2b_d1", 64'(d_idx[1]), 64'd70);
    check_val("b2b_d2", 64'(d_idx[2]), 64'd106);

    // asynchronous reset in the middle of MRUN
    @(negedge clk);
    op = 1'b0; a = 32'd7; b = 32'hFFFF_FFFD; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset_in = 1'b0;
    #1;
    check_val("mrst_busy", {63'd0, busy}, 64'd0);
    check_val("mrst_done", {63'd0, done}, 64'd0);
    check_val("mrst_hi", {32'd0, hi}, 64'd0);
    check_val("mrst_lo", {32'd0, lo}, 64'd0);
    $display("mid-op reset: busy=%0d done=%0d hi=%08h lo=%08h", busy, done, hi, lo);
    repeat (2) @(negedge clk);
    reset_in = 1'b1;
    run_op("mul_2x3", 1'b0, 32'd2, 32'd3, 0, 34, 32'd0, 32'd6, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
